// File: rtl/lsu_pkg.sv
// Shared LSU types: RV32I funct3 codes, FSM state encoding, funct3 legality and alignment helpers.
// No logic latency; no flow control.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_RESP
    } lsu_state_t;

    function automatic logic f3_legal(input logic wen, input logic [2:0] f3);
        if (wen)
            return f3 inside {F3_SB, F3_SH, F3_SW};
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    // Size lives in funct3[1:0]: 01 = halfword, 10 = word.
    function automatic logic f3_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response bundle and memory-side bus bundle for the LSU.
// Pure wiring; valid/ready on requests, responses are unthrottled pulses.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (output req_valid, req_wen, req_funct3, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface lsu_mem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
                    input  mem_ready, mem_rvalid, mem_rdata);
    modport slave  (input  mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
                    output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data replication and load byte/half extraction with extension.
// Purely combinational, zero latency; no flow control.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        wmask     = 4'b1111;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                wmask     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                // A halfword at offset 3 loses its upper byte off the top of the word.
                wmask     = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_byte   = rdata[{addr_lo, 3'b000} +: 8];
        rd_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = rdata;
        case (funct3)
            F3_LB:   rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            F3_LBU:  rdata_ext = {24'h0, rd_byte};
            F3_LH:   rdata_ext = {{16{rd_half[15]}}, rd_half};
            F3_LHU:  rdata_ext = {16'h0, rd_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit; LSU_MISALIGN_TRAP_EN turns misaligned LH/LHU/LW/SH/SW into error responses.
// Latency fire->resp: load 3, store 2, illegal 1 cycle with zero-wait memory; timeout after TIMEOUT_CYCLES.
// One access in flight: req_ready only in IDLE; mem_* held until mem_ready; resp is a pulse with no backpressure.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 9) ? $clog2(TIMEOUT_CYCLES + 1) : 9;

    lsu_state_t  state_q, state_d;
    logic        wen_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [CW-1:0] cnt_q;

    logic        fire;
    logic        req_ok;
    logic        tmo;
    logic        tmo_hit;
    logic [3:0]  wmask;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;

    assign fire = req.req_valid && (state_q == ST_IDLE);
    // Fires on the cycle whose edge brings the counter up to TIMEOUT_CYCLES.
    assign tmo  = (int'(cnt_q) + 1) >= TIMEOUT_CYCLES;

    always_comb begin
        req_ok = f3_legal(req.req_wen, req.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (f3_misaligned(req.req_funct3[1:0], req.req_addr[1:0]))
            req_ok = 1'b0;
`endif
    end

    lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem.mem_rdata),
        .wmask     (wmask),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE:
                if (fire) state_d = req_ok ? ST_REQ : ST_RESP;
            ST_REQ:
                if (mem.mem_ready && wen_q) begin
                    state_d = ST_RESP;
                end else if (tmo) begin
                    state_d = ST_RESP;
                    tmo_hit = 1'b1;
                end else if (mem.mem_ready) begin
                    state_d = ST_WAIT_R;
                end
            ST_WAIT_R:
                if (mem.mem_rvalid) begin
                    state_d = ST_RESP;
                end else if (tmo) begin
                    state_d = ST_RESP;
                    tmo_hit = 1'b1;
                end
            ST_RESP:
                state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req.req_ready   = (state_q == ST_IDLE);
        mem.mem_valid   = (state_q == ST_REQ);
        mem.mem_wen     = (state_q == ST_REQ) && wen_q;
        mem.mem_wmask   = ((state_q == ST_REQ) && wen_q) ? wmask : 4'b0000;
        mem.mem_addr    = {addr_q[31:2], 2'b00};
        mem.mem_wdata   = wdata_rep;
        req.resp_valid  = (state_q == ST_RESP);
        req.resp_err    = (state_q == ST_RESP) && err_q;
        req.resp_rdata  = (state_q == ST_RESP) ? rdata_q : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (fire) begin
                wen_q   <= req.req_wen;
                f3_q    <= req.req_funct3;
                addr_q  <= req.req_addr;
                wdata_q <= req.req_wdata;
                rdata_q <= 32'h0;
                err_q   <= !req_ok;
                cnt_q   <= '0;
            end
            if (state_q == ST_REQ || state_q == ST_WAIT_R)
                cnt_q <= cnt_q + 1'b1;
            if (tmo_hit)
                err_q <= 1'b1;
            // Returns outside WAIT_R (late, post-timeout, post-reset) never land here.
            if (state_q == ST_WAIT_R && mem.mem_rvalid)
                rdata_q <= rdata_ext;
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent waiting on memory before the access is aborted with an error.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req_valid  input  1  execute stage presents a memory access.
REQ-005 req_ready  output  1  lsu accepts a request this cycle.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code: LB/LH/LW/LBU/LHU or SB/SH/SW.
REQ-008 req_addr  input  32  effective byte address, taken from the ALU result.
REQ-009 req_wdata  input  32  store data (rs2).
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 resp_err  output  1  access faulted; qualified by resp_valid.
REQ-013 mem_valid / mem_ready  output / input  1 / 1  memory request handshake.
REQ-014 mem_addr  output  32  word-aligned address, {req_addr[31:2], 2'b00}.
REQ-015 mem_wen, mem_wmask, mem_wdata  output  1, 4, 32  store enable, byte lanes, and lane-replicated data.
REQ-016 mem_rvalid, mem_rdata  input  1, 32  load return; at most one return per issued load.

Function
REQ-017 The FSM SHALL have four states, IDLE, REQ, WAIT_R and RESP, with req_ready = (state==IDLE).
- Fire = req_valid && req_ready.
- On fire, funct3, addr, wdata and wen are captured.
REQ-018 Transitions:
- IDLE->REQ on a legal fire.
- REQ->WAIT_R on mem_ready for a load; REQ->RESP on mem_ready for a store.
- WAIT_R->RESP on mem_rvalid.
- RESP->IDLE unconditionally.
REQ-019 mem_valid SHALL be high exactly in REQ, with mem_addr, mem_wen, mem_wmask and mem_wdata held stable until mem_ready.
REQ-020 resp_valid SHALL be high exactly in RESP, with no backpressure.
- Load latency from fire to resp_valid is 3 cycles with zero-wait memory.
- Store latency is 2 cycles.
REQ-021 Load data SHALL be registered on mem_rvalid.
- Byte lane is selected by addr[1:0] and halfword by addr[1].
- LB/LH are sign-extended; LBU/LHU are zero-extended; LW passes through.
REQ-022 Store masks:
- SB: 4'b0001<<addr[1:0], data {4{wdata[7:0]}}.
- SH: 4'b0011<<addr[1:0] truncated to 4 bits, data {2{wdata[15:0]}}.
- SW: 4'b1111, data = wdata.
REQ-023 Illegal funct3 (load 3/6/7; store 3..7) SHALL go IDLE->RESP with resp_err=1 and no memory transaction.
REQ-024 A 9-bit-or-wider wait counter SHALL clear on entering REQ and increment in REQ and WAIT_R.
- On reaching TIMEOUT_CYCLES: go to RESP with resp_err=1 and drop mem_valid.
- The counter is not cleared by the REQ->WAIT_R transition.
REQ-025 mem_rvalid SHALL be ignored outside WAIT_R, so late returns after a timeout or reset are discarded.
REQ-026 mem_ready and mem_rvalid asserted in the same REQ cycle SHALL be handled as the handshake only; the return is taken in WAIT_R.

Reset
REQ-027 With rst high, state SHALL be IDLE at the next edge, from any state including mid-transaction.
- Outputs: req_ready=1; resp_valid, resp_err, mem_valid, mem_wen=0; mem_wmask=0; resp_rdata=0; counter=0.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN, when defined:
- Misaligned accesses (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL go IDLE->RESP with resp_err=1, resp_rdata=0 and no memory transaction.
REQ-029 Without LSU_MISALIGN_TRAP_EN, misaligned accesses SHALL be issued per REQ-021/022.
- Out-of-word bytes are dropped and resp_err=0.

Structure
REQ-030 Package lsu_pkg SHALL hold the funct3 constants (LB..LHU, SB..SW) and the state enum typedef.
REQ-031 Combinational sub-module lsu_align SHALL compute wmask, wdata replication, and load extraction/extension; lsu holds the FSM, counter and capture registers.

Verification
REQ-032 Load LB:
- Stimulus: addr 0x80000003; mem_rdata 0x80FF1234; zero-wait memory.
- Response: resp_rdata 0xFFFFFF80, resp_err=0, resp_valid 3 cycles after fire.
REQ-033 Store SH:
- Stimulus: addr 0x80000002, wdata 0x0000BEEF.
- Response: mem_wmask 4'b1100, mem_wdata 0xBEEFBEEF, mem_addr 0x80000000.
REQ-034 Backpressure:
- Stimulus: mem_ready low for 5 cycles.
- Response: mem_* signals stable, req_ready=0 throughout, completion after mem_ready.
REQ-035 Timeout:
- Stimulus: mem_rvalid never asserted, TIMEOUT_CYCLES=8.
- Response: resp_err=1 within 8 cycles of entering REQ; a later mem_rvalid is ignored.
REQ-036 Misaligned LW:
- Stimulus: LW at 0x80000001, once with LSU_MISALIGN_TRAP_EN and once without.
- Response with macro: resp_err=1 and no mem_valid.
- Response without macro: access issued, resp_err=0.
REQ-037 Reset in WAIT_R and illegal funct3:
- Stimulus: rst asserted in WAIT_R.
- Response: IDLE and req_ready=1 next cycle.
- Stimulus: store funct3=3'b100.
- Response: resp_err=1, no mem_valid.
